// File: rtl/tm_result_pkg.sv
// Shared types for the argmax result path: scan FSM states and the packed result word
// carried from the scanner through the result FIFO to the AXI-Stream output.
package tm_result_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        PUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic        last;
        logic [15:0] seq;
        logic [15:0] val;
        logic [15:0] idx;
    } result_t;

    localparam int IDX_LSB     = 0;
    localparam int VAL_LSB     = 16;
    localparam int SEQ_LSB     = 32;
    localparam int FIELD_W     = 16;
    localparam int RESULT_BITS = 48;

endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO; the head entry is read straight out of the storage registers,
// so a pushed word becomes visible on the cycle after the push.
module result_fifo
    import tm_result_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  result_t                  din,
    output result_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    result_t          r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == LW'(DEPTH));
    assign empty     = (r_count == '0);
    assign level     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/class_sum_argmax_axis.sv
// Snapshots the class sums on each finish pulse, scans them one class per cycle for the
// argmax, and streams one packed result word per sample out on an AXI-Stream master.
module class_sum_argmax_axis
    import tm_result_pkg::*;
#(
    parameter int CLASS_NUM              = 10,
    parameter int WEIGHT_LENGTH          = 16,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  finish_in,
    input  logic                                  last_in,
    input  logic signed [WEIGHT_LENGTH-1:0]       class_sums_in [CLASS_NUM],
    output logic                                  in_ready,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                                  m_axis_tlast,
    output logic [15:0]                           drop_count,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
    output state_t                                o_dbg_state
);

    localparam int IDX_W = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;

    state_t                          r_state;
    state_t                          w_state_next;
    logic signed [WEIGHT_LENGTH-1:0] r_sums [CLASS_NUM];
    logic                            r_last;
    logic signed [WEIGHT_LENGTH-1:0] r_best_val;
    logic [IDX_W-1:0]                r_best_idx;
    logic [IDX_W-1:0]                r_idx;
    logic [15:0]                     r_seq;
    logic [15:0]                     r_drop;

    logic                            w_accept;
    logic                            w_drop;
    logic                            w_last_idx;
    logic signed [WEIGHT_LENGTH-1:0] w_cand;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_full;
    logic                            w_empty;
    result_t                         w_push_word;
    result_t                         w_head;

    assign in_ready    = (r_state == IDLE) && !w_full;
    assign w_accept    = finish_in && in_ready;
    assign w_drop      = finish_in && !in_ready;
    assign w_cand      = r_sums[r_idx];
    assign w_last_idx  = (r_idx == IDX_W'(CLASS_NUM - 1));
    assign w_push      = (r_state == PUSH) && !w_full;
    assign drop_count  = r_drop;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = (CLASS_NUM == 1) ? PUSH : SCAN;
            SCAN:    if (w_last_idx) w_state_next = PUSH;
            PUSH:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLASS_NUM; i++) r_sums[i] <= '0;
            r_last     <= 1'b0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_idx      <= '0;
            r_seq      <= '0;
            r_drop     <= '0;
        end else begin
            if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sums     <= class_sums_in;
                        r_last     <= last_in;
                        r_best_val <= class_sums_in[0];
                        r_best_idx <= '0;
                        r_idx      <= IDX_W'(1);
                    end
                end
                SCAN: begin
                    // Strict compare keeps the earliest index on ties.
                    if (w_cand > r_best_val) begin
                        r_best_val <= w_cand;
                        r_best_idx <= r_idx;
                    end
                    r_idx <= r_idx + IDX_W'(1);
                end
                PUSH:    r_seq <= r_seq + 16'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_push_word      = '0;
        w_push_word.last = r_last;
        w_push_word.seq  = r_seq;
        w_push_word.val  = 16'(r_best_val);
        w_push_word.idx  = 16'(r_best_idx);
    end

    result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_word),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // AXIS: a word moves on tvalid && tready; tvalid is the FIFO's non-empty flag, so the
    // head entry (and with it tdata/tlast/tkeep) holds until it is accepted.
    assign m_axis_tvalid = !w_empty;
    assign w_pop         = m_axis_tvalid && m_axis_tready;
    assign m_axis_tkeep  = {(C_M00_AXIS_TDATA_WIDTH/8){m_axis_tvalid}};

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tlast = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata[IDX_LSB +: FIELD_W] = w_head.idx;
            m_axis_tdata[VAL_LSB +: FIELD_W] = w_head.val;
            m_axis_tdata[SEQ_LSB +: FIELD_W] = w_head.seq;
            m_axis_tlast                     = w_head.last;
        end
    end

endmodule

// File: tb/tb_class_sum_argmax_axis.sv
// Bench for class_sum_argmax_axis: fixed argmax vectors, hand-built corner sequences and a
// randomized run against a cycle-level model of the result stream.
module tb_class_sum_argmax_axis;
    import tm_result_pkg::*;

    localparam int CN = 10;
    localparam int WL = 16;
    localparam int DW = 64;
    localparam int FD = 4;
    localparam int EW = DW + 1;

    typedef logic signed [WL-1:0] sums_t [CN];
    typedef struct {
        sums_t s;
        logic  lst;
        int    exp_idx;
        int    exp_val;
    } vec_t;

    logic                 clk;
    logic                 rst;
    logic                 finish_in;
    logic                 last_in;
    logic signed [WL-1:0] class_sums_in [CN];
    logic                 in_ready;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic [DW-1:0]        m_axis_tdata;
    logic [DW/8-1:0]      m_axis_tkeep;
    logic                 m_axis_tlast;
    logic [15:0]          drop_count;
    logic [$clog2(FD):0]  fifo_level;
    state_t               o_dbg_state;

    class_sum_argmax_axis #(
        .CLASS_NUM              (CN),
        .WEIGHT_LENGTH          (WL),
        .C_M00_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH             (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .finish_in     (finish_in),
        .last_in       (last_in),
        .class_sums_in (class_sums_in),
        .in_ready      (in_ready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .drop_count    (drop_count),
        .fifo_level    (fifo_level),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            since_acc;
    int            n_accept;
    int            n_xfer;
    int            n_tlast;
    logic [15:0]   mdl_seq;
    logic [15:0]   exp_drop;
    logic [15:0]   last_xfer_seq;
    logic [15:0]   tlast_seq;
    logic [EW-1:0] exp_q [$];
    int            avail_q [$];
    vec_t          tbl [6];

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk_word(input int idx, input int val, input logic [15:0] sq,
                                              input logic lst);
        return {lst, 16'h0000, sq, 16'(val), 16'(idx)};
    endfunction

    // Argmax as defined: first index holding the largest signed value.
    function automatic logic [EW-1:0] model_word(input sums_t s, input logic lst, input logic [15:0] sq);
        int bi = 0;
        int bv = int'(s[0]);
        for (int i = 1; i < CN; i++) begin
            if (int'(s[i]) > bv) begin
                bv = int'(s[i]);
                bi = i;
            end
        end
        return mk_word(bi, bv, sq, lst);
    endfunction

    function automatic sums_t mk_sums(input int v [CN]);
        sums_t s;
        for (int i = 0; i < CN; i++) s[i] = 16'(v[i]);
        return s;
    endfunction

    function automatic sums_t fill_sums(input int v);
        sums_t s;
        for (int i = 0; i < CN; i++) s[i] = 16'(v);
        return s;
    endfunction

    function automatic sums_t rand_sums();
        sums_t s;
        int    v;
        for (int i = 0; i < CN; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                v    = int'($urandom_range(0, 6)) - 3;
                s[i] = 16'(v);
            end else begin
                s[i] = 16'($urandom);
            end
        end
        return s;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        avail_q.delete();
        since_acc = 100;
        mdl_seq   = '0;
        exp_drop  = '0;
        n_accept  = 0;
        n_xfer    = 0;
        n_tlast   = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        finish_in     = 1'b0;
        last_in       = 1'b0;
        m_axis_tready = 1'b0;
        class_sums_in = fill_sums(0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: compare outputs against the model, then drive the next inputs.
    task automatic step(input logic fin, input logic lst, input sums_t s, input logic rdy);
        logic exp_valid;
        logic pred_ready;
        int   lvl;
        @(negedge clk);
        cyc++;
        since_acc++;
        lvl = 0;
        foreach (avail_q[i]) if (avail_q[i] <= cyc) lvl++;
        exp_valid  = (lvl > 0);
        pred_ready = (since_acc > CN) && (lvl < FD);
        check("tvalid", EW'(m_axis_tvalid), EW'(exp_valid));
        if (exp_valid) check("result_word", {m_axis_tlast, m_axis_tdata}, exp_q[0]);
        check("tkeep", EW'(m_axis_tkeep), exp_valid ? EW'(8'hFF) : EW'(0));
        check("fifo_level", EW'(fifo_level), EW'(lvl));
        check("in_ready", EW'(in_ready), EW'(pred_ready));
        check("drop_count", EW'(drop_count), EW'(exp_drop));
        class_sums_in = s;
        last_in       = lst;
        finish_in     = fin;
        m_axis_tready = rdy;
        if (m_axis_tvalid && rdy) begin
            n_xfer++;
            last_xfer_seq = m_axis_tdata[47:32];
            if (m_axis_tlast) begin
                n_tlast++;
                tlast_seq = m_axis_tdata[47:32];
            end
        end
        if (exp_valid && rdy) begin
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
        end
        if (fin) begin
            if (pred_ready) begin
                exp_q.push_back(model_word(s, lst, mdl_seq));
                avail_q.push_back(cyc + CN + 1);
                mdl_seq++;
                n_accept++;
                since_acc = 0;
            end else if (exp_drop != 16'hFFFF) begin
                exp_drop++;
            end
        end
    endtask

    task automatic idle_steps(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, fill_sums(0), rdy);
    endtask

    // Single sample with tready high; checks the exact latency to tvalid.
    task automatic run_vec(input string name, input sums_t s, input logic lst, input logic [EW-1:0] exp_w);
        @(negedge clk);
        class_sums_in = s;
        last_in       = lst;
        finish_in     = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        finish_in = 1'b0;
        last_in   = 1'b0;
        check({name, "_state_scan"}, EW'(o_dbg_state), EW'(SCAN));
        check({name, "_busy"}, EW'(in_ready), EW'(0));
        repeat (CN - 1) @(negedge clk);
        check({name, "_early"}, EW'(m_axis_tvalid), EW'(0));
        @(negedge clk);
        check({name, "_tvalid"}, EW'(m_axis_tvalid), EW'(1));
        check({name, "_word"}, {m_axis_tlast, m_axis_tdata}, exp_w);
        check({name, "_tkeep"}, EW'(m_axis_tkeep), EW'(8'hFF));
        @(negedge clk);
        check({name, "_popped"}, EW'(m_axis_tvalid), EW'(0));
        check({name, "_ready"}, EW'(in_ready), EW'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        sums_t s;
        rst           = 1'b1;
        finish_in     = 1'b0;
        last_in       = 1'b0;
        m_axis_tready = 1'b0;
        class_sums_in = fill_sums(0);
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tvalid", EW'(m_axis_tvalid), EW'(0));
        check("rst_tdata", EW'(m_axis_tdata), EW'(0));
        check("rst_tkeep", EW'(m_axis_tkeep), EW'(0));
        check("rst_tlast", EW'(m_axis_tlast), EW'(0));
        check("rst_in_ready", EW'(in_ready), EW'(1));
        check("rst_drop", EW'(drop_count), EW'(0));
        check("rst_level", EW'(fifo_level), EW'(0));
        check("rst_state", EW'(o_dbg_state), EW'(IDLE));
        rst = 1'b0;

        // Fixed vectors; seq counts up from 0 across them.
        tbl[0] = '{s: mk_sums('{5, -3, 9, 9, 0, 1, 2, 3, 4, -8}), lst: 1'b0, exp_idx: 2, exp_val: 9};
        tbl[1] = '{s: fill_sums(-32768), lst: 1'b0, exp_idx: 0, exp_val: -32768};
        tbl[2] = '{s: fill_sums(7), lst: 1'b1, exp_idx: 0, exp_val: 7};
        tbl[3] = '{s: mk_sums('{-1, -2, -3, -4, -5, -6, -7, -8, -9, 32767}), lst: 1'b0, exp_idx: 9, exp_val: 32767};
        tbl[4] = '{s: mk_sums('{-100, -50, -50, -200, -51, -60, -70, -80, -90, -99}), lst: 1'b1, exp_idx: 1, exp_val: -50};
        tbl[5] = '{s: mk_sums('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1}), lst: 1'b0, exp_idx: 8, exp_val: 1};
        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), tbl[i].s, tbl[i].lst,
                    mk_word(tbl[i].exp_idx, tbl[i].exp_val, 16'(i), tbl[i].lst));

        // All at the minimum, then each index in turn raised by one.
        for (int j = 0; j < CN; j++) begin
            s    = fill_sums(-32768);
            s[j] = 16'sh8001;
            run_vec($sformatf("onehot%0d", j), s, 1'b0, mk_word(j, 16'h8001, 16'(6 + j), 1'b0));
        end

        // Back-pressure: four queue, fifth dropped, drained in order.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, rand_sums(), 1'b0);
            idle_steps(11, 1'b0);
        end
        check("bp_level_full", EW'(fifo_level), EW'(4));
        check("bp_in_ready_low", EW'(in_ready), EW'(0));
        step(1'b1, 1'b0, rand_sums(), 1'b0);
        step(1'b0, 1'b0, fill_sums(0), 1'b0);
        check("bp_drop_one", EW'(drop_count), EW'(1));
        idle_steps(10, 1'b1);
        check("bp_drained_count", EW'(n_xfer), EW'(4));
        check("bp_last_seq", EW'(last_xfer_seq), EW'(3));
        check("bp_level_empty", EW'(fifo_level), EW'(0));

        // Second finish three cycles into a scan is dropped.
        do_reset();
        step(1'b1, 1'b0, mk_sums('{1, 2, 3, 40, 5, 6, 7, 8, 9, 10}), 1'b1);
        idle_steps(2, 1'b1);
        step(1'b1, 1'b0, fill_sums(100), 1'b1);
        idle_steps(14, 1'b1);
        check("busy_drop", EW'(drop_count), EW'(1));
        check("busy_one_result", EW'(n_xfer), EW'(1));
        check("busy_seq", EW'(last_xfer_seq), EW'(0));

        // tlast only on the batch-final sample, random tready.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, (k == 2), rand_sums(), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 11; i++) step(1'b0, 1'b0, fill_sums(0), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0, fill_sums(0), 1'($urandom_range(0, 1)));
        check("tlast_xfers", EW'(n_xfer), EW'(3));
        check("tlast_count", EW'(n_tlast), EW'(1));
        check("tlast_seq", EW'(tlast_seq), EW'(2));

        // Reset mid-scan with two queued entries.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, rand_sums(), 1'b0);
            idle_steps(11, 1'b0);
        end
        step(1'b1, 1'b0, rand_sums(), 1'b0);
        idle_steps(4, 1'b0);
        check("mid_level_before", EW'(fifo_level), EW'(2));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tvalid", EW'(m_axis_tvalid), EW'(0));
        check("mid_rst_level", EW'(fifo_level), EW'(0));
        check("mid_rst_in_ready", EW'(in_ready), EW'(1));
        check("mid_rst_state", EW'(o_dbg_state), EW'(IDLE));
        model_reset();
        step(1'b1, 1'b0, rand_sums(), 1'b1);
        idle_steps(14, 1'b1);
        check("mid_rst_one_result", EW'(n_xfer), EW'(1));
        check("mid_rst_seq", EW'(last_xfer_seq), EW'(0));

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rand_sums(),
                 ($urandom_range(0, 3) != 0));
        idle_steps(60, 1'b1);
        check("rand_all_out", EW'(n_xfer), EW'(n_accept));
        check("rand_level_empty", EW'(fifo_level), EW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
